uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_ctrl_if.sv | 28 ++
 rtl/uart_fifo.sv | 49 ++++
 rtl/uart_rx_ctrl.sv | 62 ++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller slice.
package uart_pkg;
  localparam int UART_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } rx_state_e;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver handshake and host-side FIFO signals of uart_rx_ctrl.
interface uart_rx_ctrl_if import uart_pkg::*; #(
  parameter int DEPTH = UART_DEPTH
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    i_rx_data;
  logic          i_rx_data_rdy;
  logic          o_rx_ack;
  logic          i_rx_ack_clr;
  logic          i_pop;
  logic [7:0]    o_data;
  logic          o_empty;
  logic          o_full;
  logic [CW-1:0] o_count;
  logic          o_overrun;
  logic          i_clr_overrun;

  modport slave (
    input  i_rx_data, i_rx_data_rdy, i_rx_ack_clr, i_pop, i_clr_overrun,
    output o_rx_ack, o_data, o_empty, o_full, o_count, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_data_rdy, i_rx_ack_clr, i_pop, i_clr_overrun,
    input  o_rx_ack, o_data, o_empty, o_full, o_count, o_overrun
  );
endinterface

// File: rtl/uart_fifo.sv
// First-word fall-through byte FIFO with registered count/full/empty.
module uart_fifo import uart_pkg::*; #(
  parameter  int DEPTH = UART_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_uart_clk_x16,
  input  logic          i_reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wr_data,
  output logic [7:0]    data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  logic [CW-1:0] count_nxt;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge i_uart_clk_x16) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge i_uart_clk_x16) begin
    if (!i_reset && do_push) mem[wr_ptr] <= wr_data;
  end

  // Head reads as zero while empty so stale storage never leaks out after reset.
  assign data = empty ? 8'h00 : mem[rd_ptr];
endmodule

// File: rtl/uart_rx_ctrl.sv
// Receiver rdy/ack handshake, sticky overrun flag and receive FIFO.
module uart_rx_ctrl import uart_pkg::*; #(
  parameter int DEPTH = UART_DEPTH
) (
  input  logic          i_uart_clk_x16,
  input  logic          i_reset,
  uart_rx_ctrl_if.slave bus
);
  rx_state_e state, state_nxt;
  logic      capture, rx_ack, fifo_full, drop;

  always_ff @(posedge i_uart_clk_x16) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // A still-high ack_clr in IDLE is a leftover from an earlier handshake.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    rx_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_rx_data_rdy && !bus.i_rx_ack_clr) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        rx_ack = 1'b1;
        if (bus.i_rx_ack_clr) state_nxt = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!bus.i_rx_ack_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_rx_ack = rx_ack;
  assign drop         = capture && fifo_full && !bus.i_pop;

  always_ff @(posedge i_uart_clk_x16) begin
    if (i_reset)                bus.o_overrun <= 1'b0;
    else if (drop)              bus.o_overrun <= 1'b1;
    else if (bus.i_clr_overrun) bus.o_overrun <= 1'b0;
  end

  uart_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_uart_clk_x16 (i_uart_clk_x16),
    .i_reset        (i_reset),
    .push           (capture),
    .pop            (bus.i_pop),
    .wr_data        (bus.i_rx_data),
    .data           (bus.o_data),
    .count          (bus.o_count),
    .full           (fifo_full),
    .empty          (bus.o_empty)
  );

  assign bus.o_full = fifo_full;
endmodule
